// File: rtl/inst_rom_loader.sv
// Boot loader: packs a host byte stream into instruction ROM words, then releases the core.
// Optional LOADER_CHECKSUM_EN: trailing 4-byte XOR checksum checked before release.
module inst_rom_loader #(
    parameter int ADDR_WIDTH  = 10,
    parameter int CPU_WIDTH   = 32,
    parameter int HOLD_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    input  logic                  s_last,
    output logic                  rom_we,
    output logic [ADDR_WIDTH-1:0] rom_waddr,
    output logic [CPU_WIDTH-1:0]  rom_wdata,
    output logic                  cpu_rst_n,
    output logic                  enable,
    output logic                  load_busy,
    output logic                  load_done,
    output logic                  load_err,
    output logic [ADDR_WIDTH:0]   word_cnt
);

    typedef enum logic [2:0] {
        IDLE, LOAD, PAD, CSUM, HOLD, RUN, ERR
    } state_t;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

`ifdef LOADER_CHECKSUM_EN
    localparam state_t IMG_END = CSUM;
`else
    localparam state_t IMG_END = HOLD;
`endif

    state_t                state, next_state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [1:0]            byte_idx;
    logic [CPU_WIDTH-1:0]  wbuf;
    logic [HW-1:0]         hold_cnt;
    logic                  xfer, last_byte, ovf, start;
    logic                  do_wr, csum_ok;
    logic [CPU_WIDTH-1:0]  wr_word;

    assign s_ready   = (state == LOAD) || (state == CSUM);
    assign load_busy = (state == LOAD) || (state == PAD) ||
                       (state == CSUM) || (state == HOLD);
    assign xfer      = s_valid && s_ready;
    assign last_byte = (byte_idx == 2'd3);
    assign ovf       = (word_cnt == DEPTH);
    assign start     = load_start &&
                       ((state == IDLE) || (state == RUN) || (state == ERR));
    assign do_wr     = (state == PAD) ||
                       ((state == LOAD) && xfer && !ovf && last_byte);
    assign wr_word   = (state == PAD) ? wbuf : {s_data, wbuf[23:0]};

`ifdef LOADER_CHECKSUM_EN
    logic [CPU_WIDTH-1:0] csum_acc;

    assign csum_ok = ({s_data, wbuf[23:0]} == csum_acc);

    always_ff @(posedge clk) begin
        if (rst)
            csum_acc <= '0;
        else if (start)
            csum_acc <= '0;
        else if (do_wr)
            csum_acc <= csum_acc ^ wr_word;
    end
`else
    assign csum_ok = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE: if (load_start) next_state = LOAD;
            LOAD: begin
                if (xfer) begin
                    if (ovf)
                        next_state = ERR;
                    else if (s_last)
                        next_state = last_byte ? IMG_END : PAD;
                end
            end
            PAD:  next_state = IMG_END;
            CSUM: begin
                if (xfer && last_byte)
                    next_state = csum_ok ? HOLD : ERR;
            end
            HOLD: if (hold_cnt == HOLD_LAST) next_state = RUN;
            RUN:  if (load_start) next_state = LOAD;
            ERR:  if (load_start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    // Core-facing controls drop on the same edge a reload is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            rom_we    <= 1'b0;
            rom_waddr <= '0;
            rom_wdata <= '0;
            cpu_rst_n <= 1'b0;
            enable    <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
            word_cnt  <= '0;
            addr      <= '0;
            byte_idx  <= '0;
            wbuf      <= '0;
            hold_cnt  <= '0;
        end else begin
            rom_we    <= 1'b0;
            cpu_rst_n <= ((state == HOLD) || (state == RUN)) &&
                         ((next_state == HOLD) || (next_state == RUN));
            enable    <= (state == RUN) && (next_state == RUN);
            load_done <= (state == RUN) && (next_state == RUN);
            hold_cnt  <= (state == HOLD) ? hold_cnt + 1'b1 : '0;

            if (next_state == ERR)
                load_err <= 1'b1;

            if (do_wr) begin
                rom_we    <= 1'b1;
                rom_waddr <= addr;
                rom_wdata <= wr_word;
                addr      <= addr + 1'b1;
                word_cnt  <= word_cnt + 1'b1;
            end

            if (do_wr || ((state == CSUM) && xfer && last_byte)) begin
                wbuf     <= '0;
                byte_idx <= '0;
            end else if (xfer && ((state == CSUM) || !ovf)) begin
                wbuf[{byte_idx, 3'b000} +: 8] <= s_data;
                byte_idx <= byte_idx + 2'd1;
            end

            if (start) begin
                addr     <= '0;
                byte_idx <= '0;
                wbuf     <= '0;
                word_cnt <= '0;
                load_err <= 1'b0;
            end
        end
    end

endmodule
